// File: rtl/adder_pkg.sv
// Shared configuration helpers for the segmented pipelined adder:
// segment width derivation and legality of the N/STAGES pairing.
package adder_pkg;

  localparam int unsigned MIN_STAGES = 1;

  function automatic int unsigned seg_w(input int unsigned n, input int unsigned stages);
    return (stages == 0) ? n : n / stages;
  endfunction

  // N must split into STAGES equal, non-empty segments
  function automatic bit cfg_ok(input int unsigned n, input int unsigned stages);
    return (stages >= MIN_STAGES) && (n >= stages) && ((n % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational W-bit ripple-carry slice; one instance resolves one pipeline segment.
module adder_segment #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum_c,
  output logic         o_cout_c
);

  always_comb begin
    logic c;
    c       = i_cin;
    o_sum_c = '0;
    for (int i = 0; i < W; i++) begin
      o_sum_c[i] = i_a[i] ^ i_b[i] ^ c;
      c          = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
    end
    o_cout_c = c;
  end

endmodule

// File: rtl/pipelined_adder.sv
// N-bit add/subtract with the carry chain cut into STAGES registered segments, valid/ready on both sides.
// Optional signed-overflow output enabled by defining PIPELINED_ADDER_OVF_EN.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned N      = 32,
  parameter int unsigned STAGES = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         SUB,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Z,
  output logic         C_out
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic         OVF
`endif
);

  localparam int unsigned SEG_W = seg_w(N, STAGES);

  if (!cfg_ok(N, STAGES)) begin : g_cfg_check
    $error("pipelined_adder: N must be a nonzero multiple of STAGES");
  end

  logic         w_advance;
  logic [N-1:0] w_y_eff;

  // Whole pipe moves as one; only a held result at the output can stall it
  assign w_advance = !g_stage[STAGES-1].r_vld || out_ready;
  assign in_ready  = w_advance && !RST;
  assign w_y_eff   = SUB ? ~Y : Y;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned LO = k * SEG_W;
    localparam int unsigned HI = LO + SEG_W;

    logic [N-LO-1:0]  w_x_src;
    logic [N-LO-1:0]  w_y_src;
    logic [SEG_W-1:0] w_sum;
    logic             w_cin;
    logic             w_cout;
    logic             w_vin;
    logic [HI-1:0]    r_res;
    logic             r_vld;
    logic             r_cy;

    if (k == 0) begin : g_head
      assign w_x_src = X;
      assign w_y_src = w_y_eff;
      assign w_cin   = SUB;
      assign w_vin   = in_valid;

      always_ff @(posedge CLK) begin
        if (RST)            r_res <= '0;
        else if (w_advance) r_res <= w_sum;
      end
    end else begin : g_tail
      assign w_x_src = g_stage[k-1].g_fwd.r_x;
      assign w_y_src = g_stage[k-1].g_fwd.r_y;
      assign w_cin   = g_stage[k-1].r_cy;
      assign w_vin   = g_stage[k-1].r_vld;

      always_ff @(posedge CLK) begin
        if (RST)            r_res <= '0;
        else if (w_advance) r_res <= {w_sum, g_stage[k-1].r_res};
      end
    end

    adder_segment #(.W(SEG_W)) u_seg (
      .i_a      (w_x_src[SEG_W-1:0]),
      .i_b      (w_y_src[SEG_W-1:0]),
      .i_cin    (w_cin),
      .o_sum_c  (w_sum),
      .o_cout_c (w_cout)
    );

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
      end else if (w_advance) begin
        r_vld <= w_vin;
        r_cy  <= w_cout;
      end
    end

    // Operand slices not yet consumed travel alongside the partial result
    if (k + 1 < STAGES) begin : g_fwd
      logic [N-HI-1:0] r_x;
      logic [N-HI-1:0] r_y;

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_x <= '0;
          r_y <= '0;
        end else if (w_advance) begin
          r_x <= w_x_src[N-LO-1:SEG_W];
          r_y <= w_y_src[N-LO-1:SEG_W];
        end
      end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    // Carry-in XOR carry-out of the MSB, expressed via operand/result sign bits
    if (k + 1 == STAGES) begin : g_ovf
      logic r_ovf;

      always_ff @(posedge CLK) begin
        if (RST)            r_ovf <= 1'b0;
        else if (w_advance) r_ovf <= (w_x_src[SEG_W-1] == w_y_src[SEG_W-1]) &&
                                     (w_sum[SEG_W-1] != w_x_src[SEG_W-1]);
      end
    end
`endif
  end

  assign out_valid = g_stage[STAGES-1].r_vld;
  assign Z         = g_stage[STAGES-1].r_res;
  assign C_out     = g_stage[STAGES-1].r_cy;
`ifdef PIPELINED_ADDER_OVF_EN
  assign OVF       = g_stage[STAGES-1].g_ovf.r_ovf;
`endif

endmodule
